multibyte_add_sequencer: RTL
============================

Name: multibyte_add_sequencer

Overview:
Sequences a multi-byte add or subtract through one shared 8-bit ripple adder (the existing parallel_adder, instantiated once inside this block), one byte slice per clock, LSB first. The inter-byte carry is held in a register between slices. Operands enter and results leave through valid/ready handshakes. It is the control wrapper that lets the 8-bit adder serve 16/24/32-bit arithmetic in the design.

Parameters:
NBYTES, 4, operand width in bytes; legal range 2..8; operand width W = 8*NBYTES.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand request valid.
in_ready  output  1  block can accept an operand request.
op_a  input  W  operand A.
op_b  input  W  operand B.
op_sub  input  1  0 = A+B+cin, 1 = A-B (two's complement).
op_cin  input  1  carry-in for add; ignored when op_sub=1.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
res_sum  output  W  sum/difference.
res_cout  output  1  final carry out (sub: 1 = no borrow).
res_ovf  output  1  signed overflow.
busy  output  1  high in RUN or DONE.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high. Ports are named clk and rst.
- Reset values: in_ready=1, out_valid=0, busy=0, res_sum=0, res_cout=0, res_ovf=0. FSM resets to IDLE, slice index to 0, carry register to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge, latch op_a and op_b into internal registers. When op_sub=1, op_b is stored bitwise-inverted.
  - Set the carry register to op_sub ? 1 : op_cin, set idx=0, clear res_sum, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle the adder receives A[8*idx+:8], B'[8*idx+:8] and the carry register.
  - At the edge: write the adder Sum into res_sum[8*idx+:8], load the adder Cout into the carry register, then increment idx.
  - When idx = NBYTES-1 at the edge:
    - res_cout = final Cout.
    - res_ovf = (A[W-1] == B'[W-1]) && (Sum[7] != A[W-1]).
    - Go to DONE.
  - Exactly NBYTES RUN cycles per operation.
- DONE:
  - out_valid=1; res_sum, res_cout and res_ovf are held stable while out_ready=0.
  - On out_ready at an edge, go to IDLE; out_valid drops the next cycle.
  - in_ready stays 0 in DONE. There is no accept in the same cycle as result handoff, so back-to-back throughput is one op per NBYTES+2 cycles.
- Latency: the accept edge is E0. out_valid is first high in the cycle after edge E0+NBYTES, i.e. NBYTES cycles after accept.
- res_sum partial bytes: these may be observed during RUN but are only valid while out_valid=1.
- in_valid during RUN/DONE: ignored and not queued. The requester must hold the request until in_ready.
- Operand changes after accept: have no effect.
- Reset mid-RUN or mid-DONE: the operation is aborted immediately and all outputs take their reset values. No result is produced.
- Wrap-around: the result is modulo 2^W. Carry out of the top byte goes only to res_cout.
- Simultaneous in_valid and out_ready in DONE: out_ready is honoured, in_valid is ignored that cycle.
- res_ovf: also valid for subtraction, computed on the inverted B.

Test Plan:
- NBYTES=4, add 0x000000FF+0x00000001, cin=0 -> res_sum=0x00000100, cout=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge.
- Add 0xFFFFFFFF+0x00000000, cin=1 -> res_sum=0x00000000, cout=1, ovf=0. This checks carry propagation across all byte boundaries.
- Sub 0x00000005-0x00000007 -> res_sum=0xFFFFFFFE, cout=0, ovf=0. Sub 0x80000000-0x00000001 -> 0x7FFFFFFF, cout=1, ovf=1.
- Add 0x7FFFFFFF+0x00000001 -> 0x80000000, ovf=1, cout=0. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, and a new in_valid during this window is not accepted.
- Assert rst for 1 cycle when idx=2 in RUN -> outputs immediately return to reset values, out_valid never asserts, and in_ready=1 after reset release. A following add of 1+1 returns 0x00000002 with no stale carry.
- NBYTES=2, back-to-back ops with out_ready tied high and in_valid held high -> one result every 4 cycles, each result correct, no request lost or duplicated.

Source files
------------

// File: rtl/multibyte_add_sequencer.sv
// Byte-serial multi-byte add/subtract through one shared 8-bit adder.
// Operands in and results out via valid/ready handshakes.
module parallel_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

module multibyte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  op_sub,
  input  logic                  op_cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   res_sum,
  output logic                  res_cout,
  output logic                  res_ovf,
  output logic                  busy
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry;
  logic [IW-1:0]   idx;
  logic [7:0]      a_sl;
  logic [7:0]      b_sl;
  logic [7:0]      sum;
  logic            cout;

  assign a_sl = a_q[8*idx +: 8];
  assign b_sl = b_q[8*idx +: 8];

  parallel_adder #(
    .WIDTH(8)
  ) u_add (
    .a   (a_sl),
    .b   (b_sl),
    .cin (carry),
    .sum (sum),
    .cout(cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= op_a;
            b_q      <= op_sub ? ~op_b : op_b;
            carry    <= op_sub | op_cin;
            idx      <= '0;
            res_sum  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          res_sum[8*idx +: 8] <= sum;
          carry               <= cout;
          idx                 <= idx + 1'b1;
          if (idx == LAST) begin
            // top slice: sign bits of A/B' live in this slice
            res_cout  <= cout;
            res_ovf   <= (a_q[W-1] == b_q[W-1]) &&
                         (sum[7] != a_q[W-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
